forward_decision_unit: RTL

//  Parametrised successor to the single-compare forwarding check.
//  On start: decides deliver-local (destinationID == MY_NODE_ID) or forward.

---
 rtl/forward_decision_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/forward_decision_unit.sv
// ============================================================================
//  Module      : forward_decision_unit
//  Description : Deliver-local / forward decision with a sequential scan of a
//                programmable route table (one entry per cycle).
//                Optional macro BROADCAST_ID_EN: all-ones destination is both
//                delivered locally and forwarded, without a table scan.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module forward_decision_unit #(
    parameter int WORD_WIDTH  = 16,
    parameter int TABLE_DEPTH = 8,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic                  cfg_we,
    input  logic [IDX_WIDTH-1:0]  cfg_addr,
    input  logic [WORD_WIDTH-1:0] cfg_id,
    input  logic                  cfg_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  isDestination,
    output logic                  iamForwarding,
    output logic [IDX_WIDTH-1:0]  matchIndex
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(TABLE_DEPTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [WORD_WIDTH-1:0] r_dest;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [TABLE_DEPTH-1:0] r_valid;
    logic [WORD_WIDTH-1:0] r_id [TABLE_DEPTH];

    logic w_local;
    logic w_bcast;
    logic w_hit;
    logic w_cfg_ok;

    assign w_local = (destinationID == MY_NODE_ID);

`ifdef BROADCAST_ID_EN
    assign w_bcast = (destinationID == {WORD_WIDTH{1'b1}});
`else
    assign w_bcast = 1'b0;
`endif

    assign w_hit    = r_valid[r_idx] && (r_id[r_idx] == r_dest);
    assign w_cfg_ok = cfg_we && (r_state == S_IDLE) && (32'(cfg_addr) < TABLE_DEPTH);

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (w_local || w_bcast) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_hit || (r_idx == c_LAST_IDX)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Results are cleared on an accepted start and then only ever set, so they
    // hold from done until the next accepted start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dest        <= '0;
            r_idx         <= '0;
            isDestination <= 1'b0;
            iamForwarding <= 1'b0;
            matchIndex    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dest        <= destinationID;
                        r_idx         <= '0;
                        isDestination <= w_local || w_bcast;
                        iamForwarding <= w_bcast;
                        matchIndex    <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        iamForwarding <= 1'b1;
                        matchIndex    <= r_idx;
                    end else if (r_idx != c_LAST_IDX) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (w_cfg_ok) begin
            r_valid[cfg_addr] <= cfg_valid;
        end
    end

    // IDs need no reset: an entry is only consulted when its valid bit is set.
    always_ff @(posedge clock) begin
        if (w_cfg_ok) begin
            r_id[cfg_addr] <= cfg_id;
        end
    end

endmodule

`default_nettype wire
